// File: rtl/v_divider_5.sv
// Radix-2 restoring divider that back-solves a multiply-add: Q = (RES - C) / B, REM = (RES - C) % B.
// One quotient bit per clock under a START/DONE handshake; error cases finish right after PREP.
module v_divider_5 #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             START,
    input  logic [2*W-1:0]   RES,
    input  logic [W-1:0]     C,
    input  logic [W-1:0]     B,
    output logic             BUSY,
    output logic             DONE,
    output logic [2*W-1:0]   Q,
    output logic [W-1:0]     REM,
    output logic             DIV0,
    output logic             UFLOW
);

    localparam int CW = $clog2(2*W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2
    } state_t;

    state_t            r_state;
    logic [2*W-1:0]    r_res;
    logic [W-1:0]      r_c;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_prem;
    logic [2*W-1:0]    r_sr;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [2*W-1:0]    r_q;
    logic [W-1:0]      r_rem;
    logic              r_div0;
    logic              r_uflow;

    logic [2*W:0]      w_diff;
    logic              w_borrow;
    logic              w_bzero;
    logic [W:0]        w_shift;
    logic              w_ge;
    logic [W-1:0]      w_prem_nxt;
    logic [2*W-1:0]    w_sr_nxt;

    // Dividend preparation and one restoring step; the shift register carries
    // dividend bits out of the MSB while quotient bits enter at the LSB.
    always_comb begin
        w_diff   = {1'b0, r_res} - {{(W+1){1'b0}}, r_c};
        w_borrow = w_diff[2*W];
        w_bzero  = (r_b == {W{1'b0}});
        w_shift  = {r_prem, r_sr[2*W-1]};
        w_ge     = (w_shift >= {1'b0, r_b});
        if (w_ge) begin
            w_prem_nxt = w_shift[W-1:0] - r_b;
        end else begin
            w_prem_nxt = w_shift[W-1:0];
        end
        w_sr_nxt = {r_sr[2*W-2:0], w_ge};
    end

    // Control FSM, operand capture, iteration datapath and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_res   <= {(2*W){1'b0}};
            r_c     <= {W{1'b0}};
            r_b     <= {W{1'b0}};
            r_prem  <= {W{1'b0}};
            r_sr    <= {(2*W){1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= {(2*W){1'b0}};
            r_rem   <= {W{1'b0}};
            r_div0  <= 1'b0;
            r_uflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_res   <= RES;
                        r_c     <= C;
                        r_b     <= B;
                        r_busy  <= 1'b1;
                        r_state <= S_PREP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PREP: begin
                    if (w_bzero || w_borrow) begin
                        r_q     <= {(2*W){1'b1}};
                        r_rem   <= {W{1'b0}};
                        r_div0  <= w_bzero;
                        r_uflow <= w_borrow;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_prem  <= {W{1'b0}};
                        r_sr    <= w_diff[2*W-1:0];
                        r_cnt   <= CW'(2*W-1);
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_prem <= w_prem_nxt;
                    r_sr   <= w_sr_nxt;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == {CW{1'b0}}) begin
                        r_q     <= w_sr_nxt;
                        r_rem   <= w_prem_nxt;
                        r_div0  <= 1'b0;
                        r_uflow <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_ITER;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY  = r_busy;
    assign DONE  = r_done;
    assign Q     = r_q;
    assign REM   = r_rem;
    assign DIV0  = r_div0;
    assign UFLOW = r_uflow;

endmodule

// File: tb/tb_v_divider_5.sv
// Self-checking bench for v_divider_5: directed scenarios with literal expectations plus
// randomized operations compared every cycle against a latency/arithmetic reference model.
module tb_v_divider_5;

    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             START;
    logic [2*W-1:0]   RES;
    logic [W-1:0]     C;
    logic [W-1:0]     B;
    logic             BUSY;
    logic             DONE;
    logic [2*W-1:0]   Q;
    logic [W-1:0]     REM;
    logic             DIV0;
    logic             UFLOW;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    v_divider_5 #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .START (START),
        .RES   (RES),
        .C     (C),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .Q     (Q),
        .REM   (REM),
        .DIV0  (DIV0),
        .UFLOW (UFLOW)
    );

    typedef struct packed {
        logic [2*W-1:0] q;
        logic [W-1:0]   rem;
        logic           dz;
        logic           uf;
    } res_t;

    function automatic res_t model(input logic [2*W-1:0] res, input logic [W-1:0] c,
                                   input logic [W-1:0] b);
        res_t r;
        logic [2*W-1:0] d;
        logic [2*W-1:0] bx;
        r.dz = (b == '0);
        r.uf = (res < {{W{1'b0}}, c});
        if (r.dz || r.uf) begin
            r.q   = '1;
            r.rem = '0;
        end else begin
            d     = res - {{W{1'b0}}, c};
            bx    = {{W{1'b0}}, b};
            r.q   = d / bx;
            r.rem = W'(d % bx);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts edges to completion, publishes results on the finish edge.
    logic  m_valid = 1'b0;
    logic  m_busy, m_done;
    res_t  m_out, p_out;
    int    m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_out   <= '0;
            m_cnt   <= 0;
        end else if (m_valid) begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (START) begin
                    p_out  <= model(RES, C, B);
                    m_cnt  <= (B == '0 || RES < {{W{1'b0}}, C}) ? 1 : 2*W+1;
                    m_busy <= 1'b1;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_out  <= p_out;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_busy",  32'(BUSY),  32'(m_busy));
            chk("cyc_done",  32'(DONE),  32'(m_done));
            chk("cyc_q",     32'(Q),     32'(m_out.q));
            chk("cyc_rem",   32'(REM),   32'(m_out.rem));
            chk("cyc_div0",  32'(DIV0),  32'(m_out.dz));
            chk("cyc_uflow", 32'(UFLOW), 32'(m_out.uf));
        end
    end

    task automatic run_op(input logic [2*W-1:0] r, input logic [W-1:0] c, input logic [W-1:0] b,
                          input int exp_lat);
        int lat;
        int bcnt;
        @(negedge clk);
        RES = r; C = c; B = b; START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        RES = 16'($urandom); C = 8'($urandom); B = 8'($urandom);
        bcnt = BUSY ? 1 : 0;
        lat  = 0;
        while (!DONE && lat < 60) begin
            @(negedge clk);
            lat++;
            if (BUSY) bcnt++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("busy_cycles", 32'(bcnt), 32'(exp_lat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        int gap;
        logic [2*W-1:0] rr;
        logic [W-1:0]   cc, bb;

        rst = 1'b1; START = 1'b0; RES = '0; C = '0; B = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_rem", 32'(REM), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_flags", 32'({DIV0, UFLOW}), 32'd0);
        rst = 1'b0;

        run_op(16'd7415, 8'd15, 8'd37, 17);
        chk("t1_q", 32'(Q), 32'd200);
        chk("t1_rem", 32'(REM), 32'd0);
        chk("t1_flags", 32'({DIV0, UFLOW}), 32'd0);
        chk("t1_model_q", 32'(m_out.q), 32'd200);

        run_op(16'd1000, 8'd3, 8'd7, 17);
        chk("t2_q", 32'(Q), 32'd142);
        chk("t2_rem", 32'(REM), 32'd3);
        run_op(16'hFFFF, 8'd0, 8'd1, 17);
        chk("t3_q", 32'(Q), 32'hFFFF);
        chk("t3_rem", 32'(REM), 32'd0);
        run_op(16'hFFFF, 8'd0, 8'd255, 17);
        chk("t4_q", 32'(Q), 32'd257);
        chk("t4_rem", 32'(REM), 32'd0);

        run_op(16'd100, 8'd0, 8'd0, 1);
        chk("div0_q", 32'(Q), 32'hFFFF);
        chk("div0_rem", 32'(REM), 32'd0);
        chk("div0_flags", 32'({DIV0, UFLOW}), 32'b10);
        run_op(16'd5, 8'd9, 8'd3, 1);
        chk("uflow_q", 32'(Q), 32'hFFFF);
        chk("uflow_flags", 32'({DIV0, UFLOW}), 32'b01);

        // A START while busy must be ignored and later input changes must not leak in.
        @(negedge clk);
        RES = 16'd7415; C = 8'd15; B = 8'd37; START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        repeat (3) @(negedge clk);
        RES = 16'd50; C = 8'd0; B = 8'd5; START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        dcnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (DONE) dcnt++;
        end
        chk("ign_done_count", 32'(dcnt), 32'd1);
        chk("ign_q", 32'(Q), 32'd200);

        // Reset mid-operation aborts without a DONE pulse.
        @(negedge clk);
        RES = 16'd7415; C = 8'd15; B = 8'd37; START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_q", 32'(Q), 32'd0);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        chk("mid_rst_all", 32'({DONE, DIV0, UFLOW, REM}), 32'd0);
        rst = 1'b0;
        dcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (DONE) dcnt++;
        end
        chk("mid_rst_no_done", 32'(dcnt), 32'd0);
        run_op(16'd1000, 8'd3, 8'd7, 17);
        chk("post_rst_q", 32'(Q), 32'd142);
        chk("post_rst_rem", 32'(REM), 32'd3);

        // START held high across two operations gives DONE pulses 18 cycles apart.
        @(negedge clk);
        RES = 16'd1000; C = 8'd3; B = 8'd7; START = 1'b1;
        @(negedge clk);
        RES = 16'd7415; C = 8'd15; B = 8'd37;
        gap = 0;
        while (!DONE && gap < 60) begin
            @(negedge clk);
            gap++;
        end
        chk("b2b_first_lat", 32'(gap), 32'd17);
        chk("b2b_first_q", 32'(Q), 32'd142);
        @(negedge clk);
        gap = 1;
        while (!DONE && gap < 60) begin
            if (gap == 9) chk("b2b_hold_q", 32'(Q), 32'd142);
            @(negedge clk);
            gap++;
        end
        START = 1'b0;
        chk("b2b_gap", 32'(gap), 32'd18);
        chk("b2b_second_q", 32'(Q), 32'd200);

        // Randomized operations, including divide-by-zero and underflow cases.
        for (int i = 0; i < 150; i++) begin
            rr = 16'($urandom);
            cc = 8'($urandom);
            bb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 5) == 0) rr = 16'($urandom_range(0, 32'(cc)));
            if ($urandom_range(0, 5) == 0) bb = 8'($urandom_range(1, 3));
            run_op(rr, cc, bb, (bb == 8'd0 || rr < {8'd0, cc}) ? 1 : 17);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
